// File: rtl/x1_ioctl_loader.sv
// HPS ioctl download -> dpram port A byte writer for the X1 boot/program RAM.
// A small FIFO absorbs port-A stalls; the Z80 is held in reset while an image loads.
module x1_ioctl_loader #(
   parameter int         AW          = 16,
   parameter logic [7:0] INDEX       = 8'd0,
   parameter int         DEPTH       = 4,
   parameter int         HOLD_CYCLES = 16
) (
   input  logic          clk_sys,
   input  logic          reset_n,
   input  logic          ioctl_download,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_wr,
   input  logic [24:0]   ioctl_addr,
   input  logic [7:0]    ioctl_dout,
   output logic          ioctl_wait,
   input  logic          mem_ready,
   output logic          mem_wren,
   output logic [AW-1:0] mem_addr,
   output logic [7:0]    mem_data,
   output logic          cpu_reset,
   output logic          load_done,
   output logic [AW:0]   byte_count,
   output logic          err_range,
   output logic          err_overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int HW = $clog2(HOLD_CYCLES) + 1;
   localparam logic [CW-1:0] FULL    = CW'(DEPTH);
   localparam logic [CW-1:0] NEAR    = CW'(DEPTH - 1);
   localparam logic [AW:0]   BC_MAX  = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_HOLD} state_t;

   state_t            state, state_nxt;
   logic [HW-1:0]     hold_cnt;
   logic              from_drain;
   logic [AW+7:0]     fifo_mem [DEPTH];
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count, count_nxt;
   logic              sel, out_of_range, strobe, push, pop, hold_last, enter_load;

   function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
      return (v == BC_MAX) ? v : v + (AW+1)'(1);
   endfunction

   always_comb begin
      sel          = ioctl_download && (ioctl_index == INDEX);
      out_of_range = (ioctl_addr >> AW) != 25'd0;
      strobe       = (state == ST_LOAD) && sel && ioctl_wr;
      push         = strobe && !out_of_range && (count != FULL);
      pop          = (count != '0) && mem_ready;
      count_nxt    = count + CW'(push) - CW'(pop);
      hold_last    = hold_cnt == HW'(HOLD_CYCLES - 1);
      enter_load   = sel && ((state == ST_IDLE) || (state == ST_HOLD));
   end

   always_comb begin
      state_nxt = state;
      cpu_reset = (state != ST_IDLE);
      case (state)
         ST_IDLE:  if (sel) state_nxt = ST_LOAD;
         ST_LOAD:  if (!ioctl_download) state_nxt = ST_DRAIN;
         ST_DRAIN: if ((count == '0) && !mem_wren) state_nxt = ST_HOLD;
         ST_HOLD: begin
            if (sel)            state_nxt = ST_LOAD;
            else if (hold_last) state_nxt = ST_IDLE;
         end
         default:  state_nxt = ST_HOLD;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state      <= ST_HOLD;
         hold_cnt   <= '0;
         from_drain <= 1'b0;
         load_done  <= 1'b0;
      end else begin
         state     <= state_nxt;
         hold_cnt  <= ((state == ST_HOLD) && (state_nxt == ST_HOLD)) ? hold_cnt + HW'(1) : '0;
         load_done <= (state == ST_HOLD) && (state_nxt == ST_IDLE) && from_drain;
         // Only a drained load earns load_done; the post-reset hold does not.
         if ((state == ST_DRAIN) && (state_nxt == ST_HOLD))
            from_drain <= 1'b1;
         else if (state_nxt != ST_HOLD)
            from_drain <= 1'b0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (push) fifo_mem[wr_ptr] <= {ioctl_addr[AW-1:0], ioctl_dout};
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         mem_wren     <= 1'b0;
         mem_addr     <= '0;
         mem_data     <= '0;
         ioctl_wait   <= 1'b0;
         byte_count   <= '0;
         err_range    <= 1'b0;
         err_overflow <= 1'b0;
      end else begin
         count    <= count_nxt;
         mem_wren <= pop;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr   <= rd_ptr + PW'(1);
            mem_addr <= fifo_mem[rd_ptr][AW+7:8];
            mem_data <= fifo_mem[rd_ptr][7:0];
         end
         // One slot of margin covers a strobe already launched before the HPS sees wait.
         ioctl_wait <= (state_nxt == ST_LOAD) && (count_nxt >= NEAR);
         if (enter_load) begin
            byte_count   <= '0;
            err_range    <= 1'b0;
            err_overflow <= 1'b0;
         end else begin
            if (pop) byte_count <= sat_inc(byte_count);
            if (strobe && out_of_range) err_range <= 1'b1;
            if (strobe && !out_of_range && (count == FULL)) err_overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_x1_ioctl_loader.sv
// Scoreboard bench for x1_ioctl_loader: expected writes queued at stimulus, monitor compares.
module tb_x1_ioctl_loader;

   localparam int AW = 16;
   localparam int DEPTH = 4;
   localparam int HOLD = 16;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b1;
   logic          ioctl_download = 1'b0;
   logic [7:0]    ioctl_index = 8'd0;
   logic          ioctl_wr = 1'b0;
   logic [24:0]   ioctl_addr = '0;
   logic [7:0]    ioctl_dout = '0;
   logic          ioctl_wait;
   logic          mem_ready = 1'b1;
   logic          mem_wren;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_data;
   logic          cpu_reset;
   logic          load_done;
   logic [AW:0]   byte_count;
   logic          err_range;
   logic          err_overflow;

   x1_ioctl_loader #(.AW(AW), .INDEX(8'd0), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
      .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
      .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .mem_ready(mem_ready),
      .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
      .cpu_reset(cpu_reset), .load_done(load_done), .byte_count(byte_count),
      .err_range(err_range), .err_overflow(err_overflow)
   );

   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad = 0;
   int wr_cnt = 0;
   int ld_cnt = 0;
   logic [23:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every port-A write must match the oldest expected byte.
   always @(negedge clk_sys) begin
      if (reset_n && mem_wren) begin
         wr_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got %0h expected none", {mem_addr, mem_data});
         end else begin
            check("mem_write", 32'({mem_addr, mem_data}), 32'(exp_q.pop_front()));
         end
      end
      if (load_done) ld_cnt++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic strobe(input logic [24:0] a, input logic [7:0] d);
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_wr   = 1'b1;
      tick();
      ioctl_wr   = 1'b0;
   endtask

   task automatic start_load(input logic [7:0] idx);
      ioctl_index    = idx;
      ioctl_download = 1'b1;
      tick();
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (cpu_reset !== 1'b0 && n < 500) begin
         tick();
         n++;
      end
      if (n >= 500) begin
         total++;
         bad++;
         $display("FAIL idle_timeout: got cpu_reset=%0b expected 0", cpu_reset);
      end
      repeat (2) tick();
   endtask

   int n, w0, l0, nin;
   logic oor;
   logic [24:0] a;
   logic [7:0] d;

   initial begin
      #2 reset_n = 1'b0;
      #2;
      check("rst_cpu_reset", 32'(cpu_reset), 1);
      check("rst_mem_wren", 32'(mem_wren), 0);
      check("rst_ioctl_wait", 32'(ioctl_wait), 0);
      check("rst_byte_count", 32'(byte_count), 0);
      check("rst_errs", 32'({err_range, err_overflow, load_done}), 0);
      check("rst_mem_addr_data", 32'({mem_addr, mem_data}), 0);
      repeat (3) tick();

      // Release from reset: hold exactly HOLD cycles, no load_done
      reset_n = 1'b1;
      wait_idle(n);
      check("rst_hold_len", 32'(n), HOLD);
      check("rst_no_load_done", 32'(ld_cnt), 0);

      // Straight load of 8 bytes
      w0 = wr_cnt;
      start_load(8'd0);
      check("load_cpu_reset", 32'(cpu_reset), 1);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back({16'(i), 8'hA0 + 8'(i)});
         strobe(25'(i), 8'hA0 + 8'(i));
      end
      ioctl_download = 1'b0;
      wait_idle(n);
      check("t1_hold_ge", 32'(n >= HOLD), 1);
      check("t1_writes", 32'(wr_cnt - w0), 8);
      check("t1_queue_empty", 32'(exp_q.size()), 0);
      check("t1_byte_count", 32'(byte_count), 8);
      check("t1_load_done", 32'(ld_cnt), 1);

      // Stalled port: back-pressure and overflow
      w0 = wr_cnt;
      start_load(8'd0);
      mem_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({16'h0100 + 16'(i), 8'h50 + 8'(i)});
         strobe(25'h0100 + 25'(i), 8'h50 + 8'(i));
         if (i == 1) check("t2_wait_after2", 32'(ioctl_wait), 0);
         if (i == 2) check("t2_wait_after3", 32'(ioctl_wait), 1);
      end
      check("t2_no_overflow_yet", 32'(err_overflow), 0);
      strobe(25'h0200, 8'hEE);
      check("t2_overflow", 32'(err_overflow), 1);
      check("t2_wait_full", 32'(ioctl_wait), 1);
      check("t2_stall_writes", 32'(wr_cnt - w0), 0);
      mem_ready = 1'b1;
      repeat (8) tick();
      check("t2_writes", 32'(wr_cnt - w0), 4);
      check("t2_byte_count", 32'(byte_count), 4);
      check("t2_wait_drained", 32'(ioctl_wait), 0);
      ioctl_download = 1'b0;
      wait_idle(n);
      check("t2_load_done", 32'(ld_cnt), 2);

      // Address range boundary
      w0 = wr_cnt;
      start_load(8'd0);
      check("t3_overflow_cleared", 32'(err_overflow), 0);
      strobe(25'h10000, 8'h33);
      repeat (3) tick();
      check("t3_err_range", 32'(err_range), 1);
      check("t3_no_write", 32'(wr_cnt - w0), 0);
      check("t3_byte_count", 32'(byte_count), 0);
      exp_q.push_back({16'hFFFF, 8'h44});
      strobe(25'h0FFFF, 8'h44);
      repeat (3) tick();
      check("t3_top_addr_write", 32'(wr_cnt - w0), 1);
      ioctl_download = 1'b0;
      wait_idle(n);
      check("t3_err_sticky", 32'(err_range), 1);
      check("t3_byte_count_final", 32'(byte_count), 1);

      // Foreign index is ignored
      w0 = wr_cnt;
      l0 = ld_cnt;
      start_load(8'd1);
      for (int i = 0; i < 3; i++) strobe(25'(i), 8'h77);
      repeat (3) tick();
      check("t4_cpu_reset", 32'(cpu_reset), 0);
      check("t4_no_write", 32'(wr_cnt - w0), 0);
      check("t4_byte_count_kept", 32'(byte_count), 1);
      check("t4_err_kept", 32'(err_range), 1);
      ioctl_download = 1'b0;
      ioctl_index = 8'd0;
      repeat (2) tick();
      check("t4_no_load_done", 32'(ld_cnt - l0), 0);

      // Reset during a stalled load with queued bytes
      w0 = wr_cnt;
      l0 = ld_cnt;
      start_load(8'd0);
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) strobe(25'h0300 + 25'(i), 8'h90 + 8'(i));
      check("t6_wait_before", 32'(ioctl_wait), 1);
      reset_n = 1'b0;
      #2;
      check("t6_wait_reset", 32'(ioctl_wait), 0);
      check("t6_cpu_reset", 32'(cpu_reset), 1);
      ioctl_download = 1'b0;
      tick();
      reset_n = 1'b1;
      mem_ready = 1'b1;
      repeat (10) tick();
      check("t6_no_write", 32'(wr_cnt - w0), 0);
      check("t6_byte_count", 32'(byte_count), 0);
      check("t6_cpu_reset_hold", 32'(cpu_reset), 1);
      wait_idle(n);
      check("t6_no_load_done", 32'(ld_cnt - l0), 0);

      // Random load, HPS honours ioctl_wait, random port stalls
      w0 = wr_cnt;
      l0 = ld_cnt;
      nin = 0;
      oor = 1'b0;
      start_load(8'd0);
      for (int i = 0; i < 120; i++) begin
         mem_ready = ($urandom_range(0, 3) != 0);
         if (ioctl_wait == 1'b0 && $urandom_range(0, 2) != 0) begin
            if ($urandom_range(0, 7) == 0) a = 25'h10000 + 25'($urandom_range(0, 25'h1FEFFFF));
            else                           a = 25'($urandom_range(0, 16'hFFFF));
            d = 8'($urandom);
            if (a < 25'h10000) begin
               exp_q.push_back({a[15:0], d});
               nin++;
            end else begin
               oor = 1'b1;
            end
            strobe(a, d);
         end else begin
            tick();
         end
      end
      mem_ready = 1'b1;
      ioctl_download = 1'b0;
      wait_idle(n);
      check("t7_byte_count", 32'(byte_count), 32'(nin));
      check("t7_writes", 32'(wr_cnt - w0), 32'(nin));
      check("t7_err_range", 32'(err_range), 32'(oor));
      check("t7_no_overflow", 32'(err_overflow), 0);
      check("t7_queue_empty", 32'(exp_q.size()), 0);
      check("t7_load_done", 32'(ld_cnt - l0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
